// File: rtl/uart_ctrl_pkg.sv
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Shared types and constants for the UART control blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_ctrl_pkg;

    localparam int c_byte_w                = 8;
    localparam int c_default_start_timeout = 4096;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin picker; pointer holds the last granted index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int c_idx_w = $clog2(NREQ);

    logic [c_idx_w-1:0] ptr_q;
    logic [c_idx_w-1:0] ptr_d;
    logic [c_idx_w-1:0] w_idx;
    logic [c_idx_w-1:0] w_cand;
    logic [NREQ-1:0]    w_gnt;
    logic               w_found;

    // Search begins just after the last winner, so it is lowest priority next time.
    always_comb begin
        w_gnt   = '0;
        w_idx   = ptr_q;
        w_cand  = ptr_q;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = c_idx_w'((int'(ptr_q) + i) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (w_found) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && w_found) begin
            ptr_d = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= c_idx_w'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt     = w_gnt;
    assign gnt_idx = w_idx;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART sender between NREQ byte requesters (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int START_TIMEOUT = c_default_start_timeout
) (
    input  logic                     sysclk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*c_byte_w-1:0] req_data,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          err,
    output logic [NREQ-1:0]          grant,
    output logic [c_byte_w-1:0]      tx_data,
    output logic                     tx_trigger,
    output logic                     tx_enable,
    input  logic                     tx_state
);

    localparam int c_cnt_w = $clog2(START_TIMEOUT) + 1;
    localparam int c_idx_w = $clog2(NREQ);

    tx_arb_state_e       state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     err_q, err_d;
    logic [c_byte_w-1:0] tx_data_q, tx_data_d;
    logic                trig_q, trig_d;
    logic                enable_q;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                sync1_q, sync2_q;

    logic [NREQ-1:0]     w_arb_gnt;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic                w_advance;
    logic [c_byte_w-1:0] w_req_bytes [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_bytes
        assign w_req_bytes[gi] = req_data[gi*c_byte_w +: c_byte_w];
    end

    assign w_advance = (state_q == IDLE) && (|req);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (w_advance),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_d     = '0;
        tx_data_d = tx_data_q;
        trig_d    = trig_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (w_advance) begin
                    grant_d   = w_arb_gnt;
                    tx_data_d = w_req_bytes[w_arb_idx];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                trig_d  = ~trig_q;
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                // A sender that is still busy from earlier traffic exits here at once.
                if (sync2_q) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == c_cnt_w'(START_TIMEOUT - 1)) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            WAIT_DONE: begin
                if (!sync2_q) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            tx_data_q <= '0;
            trig_q    <= 1'b0;
            enable_q  <= 1'b0;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tx_data_q <= tx_data_d;
            trig_q    <= trig_d;
            enable_q  <= 1'b1;
            cnt_q     <= cnt_d;
            sync1_q   <= tx_state;
            sync2_q   <= sync1_q;
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign tx_data    = tx_data_q;
    assign tx_trigger = trig_q;
    assign tx_enable  = enable_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed bench for uart_tx_arbiter with a simple sender model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_trigger;
    logic        tx_enable;
    logic        tx_state;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    bit mute     = 1'b0;

    logic       trig_seen;
    int         busy_cnt;

    uart_tx_arbiter #(
        .NREQ          (2),
        .START_TIMEOUT (16)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .err        (err),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_trigger (tx_trigger),
        .tx_enable  (tx_enable),
        .tx_state   (tx_state)
    );

    always #5 sysclk = ~sysclk;

    // Sender: busy 5 cycles after a trigger edge, for 100 cycles.
    always @(posedge sysclk) begin
        if (!tx_enable) begin
            tx_state  <= 1'b0;
            busy_cnt  <= 0;
            trig_seen <= tx_trigger;
        end else begin
            trig_seen <= tx_trigger;
            if (tx_trigger != trig_seen && !mute) busy_cnt <= 1;
            else if (busy_cnt != 0)               busy_cnt <= busy_cnt + 1;
            if (busy_cnt == 4) tx_state <= 1'b1;
            if (busy_cnt == 104) begin
                tx_state <= 1'b0;
                busy_cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        t++;
    endtask

    task automatic serve(input logic [1:0] exp_gnt, input logic [7:0] exp_data, input bit exp_err,
                         input logic [1:0] drop_in_frame, input logic [1:0] drop_at_done);
        int   n;
        int   g_t;
        int   fall_t;
        int   done_t;
        int   toggles;
        int   hi_cnt;
        logic trig_prev;
        logic exp_trig;
        logic st_prev;
        n = 0;
        while (grant == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        g_t = t;
        check("grant", grant, exp_gnt);
        check("tx_data", tx_data, exp_data);
        exp_trig = ~tx_trigger;
        tick();
        check("trig_toggle", tx_trigger, exp_trig);
        toggles   = 0;
        hi_cnt    = 0;
        fall_t    = -100;
        trig_prev = tx_trigger;
        st_prev   = tx_state;
        n = 0;
        while ((ack | err) == 2'b00 && n < 400) begin
            tick();
            n++;
            if (tx_trigger !== trig_prev) toggles++;
            trig_prev = tx_trigger;
            if (st_prev && !tx_state) fall_t = t;
            if (tx_state) hi_cnt++;
            if (hi_cnt == 10) req = req & ~drop_in_frame;
            st_prev = tx_state;
        end
        done_t = t;
        check("extra_toggle", toggles, 0);
        check("ack", ack, exp_err ? 2'b00 : exp_gnt);
        check("err", err, exp_err ? exp_gnt : 2'b00);
        check("grant_clear", grant, 2'b00);
        if (exp_err) check("err_latency", done_t - g_t, 17);
        else         check("ack_latency", done_t - fall_t, 3);
        req = req & ~drop_at_done;
        tick();
        check("pulse_width", ack | err, 2'b00);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        req      = 2'b00;
        req_data = 16'h0000;
        #12;
        check("rst_grant", grant, 2'b00);
        check("rst_ack_err", {ack, err}, 4'h0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_trigger", tx_trigger, 1'b0);
        check("rst_enable", tx_enable, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("enable_rise", tx_enable, 1'b1);
        check("idle_grant", grant, 2'b00);

        // Contention: both held, alternating order starting at 0
        req_data = {8'hC3, 8'h3C};
        req      = 2'b11;
        serve(2'b01, 8'h3C, 1'b0, 2'b00, 2'b00);
        serve(2'b10, 8'hC3, 1'b0, 2'b00, 2'b00);
        serve(2'b01, 8'h3C, 1'b0, 2'b00, 2'b00);
        serve(2'b10, 8'hC3, 1'b0, 2'b00, 2'b11);
        tick();
        check("idle_after_contention", grant, 2'b00);

        // Single request
        req_data = {8'h00, 8'hA5};
        req      = 2'b01;
        serve(2'b01, 8'hA5, 1'b0, 2'b00, 2'b01);

        // Start timeout, then a normal frame
        mute     = 1'b1;
        req_data = {8'h5A, 8'hA5};
        req      = 2'b10;
        serve(2'b10, 8'h5A, 1'b1, 2'b00, 2'b10);
        mute     = 1'b0;
        req_data = {8'h5A, 8'h77};
        req      = 2'b01;
        serve(2'b01, 8'h77, 1'b0, 2'b00, 2'b01);

        // Request drop during WAIT_DONE
        req_data = {8'hE1, 8'h77};
        req      = 2'b10;
        serve(2'b10, 8'hE1, 1'b0, 2'b10, 2'b00);
        repeat (4) tick();
        check("no_regrant", grant, 2'b00);

        // Back-to-back from requester 0
        req_data = {8'hE1, 8'hB2};
        req      = 2'b01;
        serve(2'b01, 8'hB2, 1'b0, 2'b00, 2'b00);
        check("b2b_regrant", grant, 2'b01);
        serve(2'b01, 8'hB2, 1'b0, 2'b00, 2'b01);

        // Reset during WAIT_DONE; pointer must restart at requester 0
        req_data = {8'h22, 8'h11};
        req      = 2'b01;
        n = 0;
        while (!tx_state && n < 50) begin
            tick();
            n++;
        end
        check("mid_frame_busy", tx_state, 1'b1);
        repeat (5) tick();
        req = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_enable", tx_enable, 1'b0);
        check("mid_rst_trigger", tx_trigger, 1'b0);
        repeat (3) tick();
        check("mid_rst_no_ack", ack, 2'b00);
        rst_n = 1'b1;
        tick();
        check("mid_rst_enable_rise", tx_enable, 1'b1);
        serve(2'b01, 8'h11, 1'b0, 2'b00, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit path between `NREQ` independent byte requesters, such as the CPU peripheral-write path and a debug/trace source. It picks one requester by round-robin and latches that requester's byte. It launches one frame on the UART sender with the sender's toggle-style trigger, then holds the grant until the sender reports the frame complete. It sits between the bus-side peripheral logic and the UART sender and baud generator pair.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `START_TIMEOUT`, 4096: sysclk cycles to wait for `tx_state` to rise after a trigger toggle before the frame is declared failed.
- `sysclk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in NREQ: per-requester level request; must stay high until the matching `ack` or `err`.
- `req_data` in NREQ*8: byte for requester i in bits [8i+7:8i]; sampled only at grant.
- `ack` out NREQ: one-cycle pulse to the granted requester when its frame completes.
- `err` out NREQ: one-cycle pulse to the granted requester on start timeout.
- `grant` out NREQ: one-hot, high from grant until ack/err; all-zero when idle.
- `tx_data` out 8: byte to the sender; stable from grant until the next grant.
- `tx_trigger` out 1: launch control; the arbiter inverts it once per frame (edge-triggered consumer).
- `tx_enable` out 1: sender/baud enable; high whenever not in reset.
- `tx_state` in 1: sender busy level, high while a frame is on the line; synchronised internally with 2 flops.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE:
  - If any `req` is high, the round-robin pick sets `grant` one-hot and latches `tx_data`. Go to LAUNCH.
  - If no `req` is high, stay in IDLE.
- LAUNCH: invert `tx_trigger`, clear the timeout counter, go to WAIT_START. Lasts exactly 1 cycle.
- WAIT_START:
  - When the synchronised `tx_state` is 1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT-1`, pulse `err` to the granted requester, clear `grant`, and go to IDLE.
- WAIT_DONE: when the synchronised `tx_state` is 0, pulse `ack` to the granted requester, clear `grant`, and go to IDLE.
- Round-robin:
  - The pointer holds the index of the last granted requester.
  - The search starts at pointer+1 and wraps modulo `NREQ`.
  - The pointer updates only on grant, so a requester that is always asserting cannot starve the others.
- `req` dropping while that requester is granted: ignored; the frame completes and `ack` is still pulsed.
- A new request from the just-served requester is eligible in the cycle after its `ack`/`err`, at lowest priority.
- Timeout counter width: $clog2(`START_TIMEOUT`)+1; it never wraps.

## Timing
- Reset values:
  - FSM = IDLE.
  - `grant` = 0, `ack` = 0, `err` = 0.
  - `tx_data` = 8'h00, `tx_trigger` = 0, `tx_enable` = 0.
  - RR pointer = `NREQ`-1, so requester 0 wins first.
  - Sync flops = 0.
- Grant latency: `req` high in IDLE produces `grant` and `tx_data` on the next edge. `tx_trigger` inverts one edge after that.
- `tx_state` synchroniser adds 2 cycles to the WAIT_START and WAIT_DONE observations.
- `ack` is asserted 3 edges after raw `tx_state` falls: 2 sync + 1 FSM register.
- Minimum request-to-request spacing: one IDLE cycle between `ack` and the next `grant`.
- `tx_state` already high at LAUNCH (sender still busy): WAIT_START exits immediately. A higher layer must not share the sender with other triggers.
- Reset mid-frame:
  - All outputs return to reset values asynchronously; no `ack` is issued.
  - `tx_trigger` returning to 0 may count as an edge at the sender. This is accepted, because the sender is also disabled through `tx_enable` = 0.
- `tx_enable` rises on the first sysclk edge after `rst_n` deasserts.

## Structure
- Package `uart_ctrl_pkg`: FSM state enum (2 bits), default `START_TIMEOUT`, byte width constant 8.
- Sub-module `rr_arbiter`:
  - Parameterised by `NREQ`.
  - Inputs: `req` vector, `advance` strobe.
  - Outputs: one-hot `gnt`, index `gnt_idx`.
  - Contains the pointer register.
  - Reused later by the receive-side dispatch.
- Top: FSM, data latch, trigger toggle flop, timeout counter, 2-flop synchroniser.

## Test plan
- Single request: `req`=2'b01, `req_data`=8'hA5; sender model raises `tx_state` 5 cycles after the trigger edge and holds it 100 cycles. Required: `tx_data`=8'hA5, exactly one `tx_trigger` inversion, `ack`[0] one cycle wide, `grant` returns to 0.
- Contention: both `req` held high, 4 frames. Required grant order 0,1,0,1; `tx_data` matches each grantee's byte.
- Start timeout: `START_TIMEOUT`=16, sender never raises `tx_state`. Required: `err` pulse 17 cycles after LAUNCH, no `ack`, next request served normally.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE. Required: `grant`=0, `tx_enable`=0 immediately; after release, requester 0 is granted first.
- Request drop: `req`[1] falls during WAIT_DONE. Required: frame completes, `ack`[1] is still pulsed, and requester 1 is not re-granted.
- Back-to-back: requester 0 reasserts the cycle after its `ack` while requester 1 is idle. Required: re-grant after exactly one IDLE cycle, with `tx_trigger` inverted again.
